// File: rtl/dmem_lsu_if.sv
// Bundle between the execute stage, the load/store unit and the data memory.
// Ports: master = CPU side plus memory read data, slave = the load/store unit.
`timescale 1ns/1ps
interface dmem_lsu_if #(
    parameter int ADDR_W = 11
);
    logic              req;
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              dm_ena;
    logic              dm_w;
    logic              dm_r;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport master (
        output req, op, addr, wdata, dm_rdata,
        input  busy, done, err, rdata,
        input  dm_ena, dm_w, dm_r, dm_addr, dm_wdata
    );

    modport slave (
        input  req, op, addr, wdata, dm_rdata,
        output busy, done, err, rdata,
        output dm_ena, dm_w, dm_r, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: byte addresses to word memory, sub-word loads, RMW stores.
// Ports: clk, rst_n (async low), bus (dmem_lsu_if.slave: CPU req/resp + memory
// strobes). Macro DMEM_LSU_ALIGN_CHECK_EN enables misalignment errors.
`timescale 1ns/1ps
module dmem_lsu #(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_idx;
    logic              r_err;

    logic              w_half;
    logic              w_word;
    logic              w_mis;
    logic              w_rmw;
    logic              w_load;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_bl;
    logic [31:0]       w_hl;
    logic [31:0]       w_ext;
    logic [31:0]       w_mask;
    logic [31:0]       w_ins;
    logic [31:0]       w_merge;

    assign w_half = (bus.op == OP_LH) || (bus.op == OP_LHU) ||
                    (bus.op == OP_SH);
    assign w_word = (bus.op == OP_LW) || (bus.op == OP_SW);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    assign w_mis = (w_half & bus.addr[0]) |
                   (w_word & (bus.addr[1:0] != 2'b00));
`else
    // Low bits are simply ignored by the lane selects below.
    assign w_mis = 1'b0 & w_half & w_word;
`endif

    // Bits above the word index are dropped, so the index wraps.
    assign w_idx  = ADDR_W'((bus.addr - BASE_ADDR) >> 2);
    assign w_rmw  = (r_op == OP_SB) || (r_op == OP_SH);
    assign w_load = (r_op <= OP_LHU);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_mis)
                        w_next = S_DONE;
                    else if (bus.op == OP_SW)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:    w_next = w_rmw ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction; halfword lane uses addr[1] only.
    always_comb begin
        w_bl  = bus.dm_rdata >> {r_lo, 3'b000};
        w_hl  = bus.dm_rdata >> {r_lo[1], 4'b0000};
        w_ext = bus.dm_rdata;
        unique case (r_op)
            OP_LB:   w_ext = {{24{w_bl[7]}}, w_bl[7:0]};
            OP_LBU:  w_ext = {24'h0, w_bl[7:0]};
            OP_LH:   w_ext = {{16{w_hl[15]}}, w_hl[15:0]};
            OP_LHU:  w_ext = {16'h0, w_hl[15:0]};
            default: w_ext = bus.dm_rdata;
        endcase
    end

    // Store merge: SW uses a full mask so the captured word drops out.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = r_wdata;
        unique case (r_op)
            OP_SB: begin
                w_mask = 32'h0000_00FF << {r_lo, 3'b000};
                w_ins  = {4{r_wdata[7:0]}};
            end
            OP_SH: begin
                w_mask = 32'h0000_FFFF << {r_lo[1], 4'b0000};
                w_ins  = {2{r_wdata[15:0]}};
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_ins  = r_wdata;
            end
        endcase
        w_merge = (r_word & ~w_mask) | (w_ins & w_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_LW;
            r_lo    <= 2'b00;
            r_wdata <= 32'h0;
            r_word  <= 32'h0;
            r_rdata <= 32'h0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_op    <= bus.op;
                        r_lo    <= bus.addr[1:0];
                        r_wdata <= bus.wdata;
                        r_idx   <= w_idx;
                        r_err   <= w_mis;
                    end
                end
                S_RD: begin
                    r_word <= bus.dm_rdata;
                    if (w_load)
                        r_rdata <= w_ext;
                end
                S_DONE:  r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;
    assign bus.dm_ena   = (r_state == S_RD) || (r_state == S_WR);
    assign bus.dm_r     = (r_state == S_RD);
    assign bus.dm_w     = (r_state == S_WR);
    assign bus.dm_addr  = r_idx;
    assign bus.dm_wdata = w_merge;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus random ops against a byte-array model.
// Ports: none; drives a dmem_lsu_if instance and a word memory model.
`timescale 1ns/1ps
module tb_dmem_lsu;
    localparam int          AW   = 11;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          NB   = 4 << AW;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LB  = 3'd1;
    localparam logic [2:0] LBU = 3'd2;
    localparam logic [2:0] LH  = 3'd3;
    localparam logic [2:0] LHU = 3'd4;
    localparam logic [2:0] SW  = 3'd5;
    localparam logic [2:0] SB  = 3'd6;
    localparam logic [2:0] SH  = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(AW)) bus ();

    dmem_lsu #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [1 << AW];
    logic [7:0]  refb [NB];
    logic [31:0] exp_rdata;
    logic [31:0] seed_w;
    logic [31:0] rd;
    int n_checks = 0;
    int n_errs   = 0;

    assign bus.dm_rdata = mem[bus.dm_addr];

    always @(posedge clk)
        if (bus.dm_ena && bus.dm_w)
            mem[bus.dm_addr] <= bus.dm_wdata;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic int off(input logic [31:0] a);
        return int'((a - BASE) & 32'(NB - 1));
    endfunction

    function automatic bit is_half(input logic [2:0] o);
        return (o == LH) || (o == LHU) || (o == SH);
    endfunction

    function automatic bit is_word(input logic [2:0] o);
        return (o == LW) || (o == SW);
    endfunction

    function automatic bit is_mis(input logic [2:0] o,
                                  input logic [31:0] a);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if (is_half(o)) return a[0];
        if (is_word(o)) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0 & o[0] & a[0];
`endif
    endfunction

    function automatic logic [31:0] align(input logic [2:0] o,
                                          input logic [31:0] a);
        if (is_half(o)) return a & ~32'd1;
        if (is_word(o)) return a & ~32'd3;
        return a;
    endfunction

    function automatic logic [31:0] ld(input logic [2:0] o,
                                       input logic [31:0] a);
        int i;
        logic [7:0] b0, b1, b2, b3;
        i  = off(a);
        b0 = refb[i];
        b1 = refb[(i + 1) % NB];
        b2 = refb[(i + 2) % NB];
        b3 = refb[(i + 3) % NB];
        case (o)
            LB:      return {{24{b0[7]}}, b0};
            LBU:     return {24'h0, b0};
            LH:      return {{16{b1[7]}}, b1, b0};
            LHU:     return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic st(input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] wd);
        int i;
        i = off(a);
        refb[i] = wd[7:0];
        if (o != SB) refb[i + 1] = wd[15:8];
        if (o == SW) begin
            refb[i + 2] = wd[23:16];
            refb[i + 3] = wd[31:24];
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] r);
        int k, nr, nw, wl, wr, ww;
        logic mis;
        logic [31:0] ea;
        logic [AW-1:0] seen, want_idx;
        mis = is_mis(o, a);
        ea  = align(o, a);
        want_idx = AW'((a - BASE) >> 2);
        if (mis) begin wl = 0; wr = 0; ww = 0; end
        else if (o <= LHU) begin wl = 1; wr = 1; ww = 0; end
        else if (o == SW) begin wl = 1; wr = 0; ww = 1; end
        else begin wl = 2; wr = 1; ww = 1; end
        @(negedge clk);
        bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        k = 0; nr = 0; nw = 0; seen = '0;
        while (!bus.done && k < 8) begin
            if (bus.dm_r) nr++;
            if (bus.dm_w) nw++;
            if (bus.dm_ena) seen = bus.dm_addr;
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(k), 32'(wl));
        check("rd_cycles", 32'(nr), 32'(wr));
        check("wr_cycles", 32'(nw), 32'(ww));
        if (wr + ww > 0) check("dm_addr", 32'(seen), 32'(want_idx));
        check("err", 32'(bus.err), 32'(mis));
        if (!mis) begin
            if (o <= LHU) exp_rdata = ld(o, ea);
            else st(o, ea, wd);
        end
        check("rdata", bus.rdata, exp_rdata);
        r = bus.rdata;
        @(posedge clk); #1;
        check("idle_after",
              {29'h0, bus.busy, bus.done, bus.err}, 32'h0);
    endtask

    initial begin : main
        int acc[$];
        int nw;
        logic pb;
        logic [2:0] o;
        logic [31:0] a;
        bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < (1 << AW); i++) begin
            seed_w = $urandom;
            mem[i] = seed_w;
            for (int b = 0; b < 4; b++) refb[4*i + b] = seed_w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {26'h0, bus.busy, bus.done, bus.err,
              bus.dm_ena, bus.dm_w, bus.dm_r}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'h0);
        check("rst_dm_wdata", bus.dm_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        do_op(SW, BASE + 4, 32'hDEADBEEF, rd);
        do_op(LW, BASE + 4, 32'h0, rd);
        check("tp_lw", rd, 32'hDEADBEEF);

        do_op(SW, BASE + 4, 32'h80FF7F01, rd);
        do_op(LB, BASE + 5, 32'h0, rd);
        check("tp_lb1", rd, 32'h0000007F);
        do_op(LB, BASE + 6, 32'h0, rd);
        check("tp_lb2", rd, 32'hFFFFFFFF);
        do_op(LBU, BASE + 7, 32'h0, rd);
        check("tp_lbu3", rd, 32'h00000080);
        do_op(LH, BASE + 6, 32'h0, rd);
        check("tp_lh2", rd, 32'hFFFF80FF);
        do_op(LHU, BASE + 6, 32'h0, rd);
        check("tp_lhu2", rd, 32'h000080FF);

        do_op(SW, BASE + 4, 32'h11223344, rd);
        do_op(SB, BASE + 6, 32'h000000AA, rd);
        do_op(LW, BASE + 4, 32'h0, rd);
        check("tp_sb", rd, 32'h11AA3344);
        do_op(SH, BASE + 4, 32'h0000BEEF, rd);
        do_op(LW, BASE + 4, 32'h0, rd);
        check("tp_sh", rd, 32'h11AABEEF);

        do_op(SW, BASE, 32'hCAFE1234, rd);
        do_op(LH, BASE + 3, 32'h0, rd);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        check("tp_mis_lh", rd, 32'h11AABEEF);
`else
        check("tp_mis_lh", rd, 32'hFFFFCAFE);
`endif

        do_op(SW, BASE + 32'h2004, 32'h0BADF00D, rd);
        do_op(LW, BASE + 4, 32'h0, rd);
        check("tp_wrap", rd, 32'h0BADF00D);

        for (int n = 0; n < 300; n++) begin
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, NB - 1));
            do_op(o, a, $urandom, rd);
        end

        @(negedge clk);
        bus.req = 1'b1; bus.op = SB; bus.addr = BASE + 8;
        bus.wdata = 32'h000000A5;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("rst_in_rd", 32'(bus.dm_r), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dm_w", 32'(bus.dm_w), 32'd0);
        check("rst_dm_ena", 32'(bus.dm_ena), 32'd0);
        nw = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.dm_w) nw++;
        end
        check("rst_no_write", 32'(nw), 32'd0);
        exp_rdata = 32'h0;
        check("rst_rdata2", bus.rdata, exp_rdata);
        @(negedge clk) rst_n = 1'b1;
        do_op(LW, BASE + 8, 32'h0, rd);

        @(negedge clk);
        bus.req = 1'b1; bus.op = LW; bus.addr = BASE + 4;
        pb = bus.busy;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.busy && !pb) acc.push_back(c);
            pb = bus.busy;
        end
        @(negedge clk) bus.req = 1'b0;
        check("held_accepts", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++)
            check("held_gap", 32'(acc[i] - acc[i-1]), 32'd3);
        exp_rdata = ld(LW, BASE + 4);
        @(posedge clk); #1;
        check("held_idle", 32'(bus.busy), 32'd0);
        check("held_rdata", bus.rdata, exp_rdata);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the CPU execute stage and the word-organised data memory. Accepts one load or store request at a time, translates byte addresses to word indices, performs byte/halfword extraction with sign or zero extension, and implements sub-word stores as read-modify-write. Drives the memory's `ena`/`dmw`/`dmr`/address/write-data strobes and consumes its combinational read data.

## Interface
- `ADDR_W`, 11: memory word-index width; drives `dm_addr`.
- `BASE_ADDR`, 32'h1001_0000: byte address mapped to word index 0.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=SW, 6=SB, 7=SH.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; SB uses [7:0], SH uses [15:0].
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse, registered.
- `err`  out  1  misalignment flag, valid with `done`.
- `rdata`  out  32  extended load result, held until the next load completes.
- `dm_ena`  out  1  memory enable.
- `dm_w`  out  1  memory write strobe.
- `dm_r`  out  1  memory read strobe.
- `dm_addr`  out  ADDR_W  word index = ((addr − BASE_ADDR) >> 2)[ADDR_W-1:0].
- `dm_wdata`  out  32  word to write.
- `dm_rdata`  in  32  memory read data, combinational from `dm_addr`.

## Operation
- Little-endian: byte lane k = `addr[1:0]` → bits [8k+7:8k]; halfword lane `addr[1]` → [16h+15:16h].
- FSM states: IDLE, RD, WR, DONE.
- IDLE: on `req`, latch `op`, `addr`, `wdata`. Misaligned (halfword with `addr[0]`=1, word with `addr[1:0]`≠0) → DONE with `err`=1, no memory access. SW → WR. All other ops → RD.
- RD: `dm_ena`=`dm_r`=1. At cycle end, capture `dm_rdata`. Loads → DONE with `rdata` updated. SB/SH → WR with captured word as merge base.
- WR: `dm_ena`=`dm_w`=1. `dm_wdata` = `wdata` (SW), or the captured word with the selected lane replaced (SB/SH).
- DONE: `done`=1 for exactly one cycle, then IDLE. `err` clears on the next IDLE cycle.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores and errored ops leave `rdata` unchanged.
- `dm_ena`/`dm_r`/`dm_w` decode combinationally from state only and are never active in IDLE or DONE.
- `req` while `busy` is ignored and not queued.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `err`, `dm_ena`, `dm_w`, `dm_r` = 0; `rdata` = 0; `dm_addr`, `dm_wdata` = 0.
- Taking `req` at edge E0:
  - Loads: RD during E0–E1; `done` and new `rdata` during E1–E2.
  - SW: WR during E0–E1 (memory writes at E1); `done` during E1–E2.
  - SB/SH: RD during E0–E1, WR during E1–E2, `done` during E2–E3.
  - Misaligned: `done`+`err` during E0–E1.
- Back-to-back: a new `req` is accepted at the edge that leaves DONE. Throughput is 1 op per 3 cycles (loads/SW) or 4 cycles (SB/SH).
- Reset mid-operation forces IDLE asynchronously and drops `dm_w` immediately, so no write occurs at the next edge. A sub-word RMW interrupted in RD leaves memory untouched.
- Address wrap: bits above the word index are discarded, so `dm_addr` wraps modulo 2^ADDR_W.

## Configuration
- `DMEM_LSU_ALIGN_CHECK_EN` defined: misalignment detection as above.
- Undefined: `err` tied 0. Low address bits are forced aligned (halfword ignores `addr[0]`, word ignores `addr[1:0]`), and the op proceeds normally.

## Test plan
- Reset, then SW to addr 0x1001_0004 with wdata 0xDEADBEEF → `dm_w` high 1 cycle at `dm_addr`=1; then LW of the same address → `rdata`=0xDEADBEEF, `done` 2 cycles after `req`.
- Word 1 = 0x80FF7F01: LB at +1 → 0x0000007F; LB at +2 → 0xFFFFFFFF; LBU at +3 → 0x00000080; LH at +2 → 0xFFFF80FF; LHU at +2 → 0x000080FF.
- Word 1 = 0x11223344: SB 0xAA at 0x1001_0006 → word becomes 0x11AA3344; SH 0xBEEF at 0x1001_0004 → 0x11AABEEF. `done` 3 cycles after `req`.
- LH at 0x1001_0003 with the macro defined → `done`+`err` in the next cycle, no `dm_ena`; without the macro → `err`=0 and the access reads lane 1.
- Assert `rst_n` low during the RD cycle of an SB → `dm_w` never asserts, memory unchanged, `busy`=0.
- `req` held high continuously with an LW → each accept is 3 cycles apart, and `req` is ignored while `busy`.
